// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking and a bounded hold time for one shared write port.
// Define RR_LOCK_ARBITER_ASSERT_EN to compile the internal consistency assertions.
module rr_lock_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           preempt
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam bit PREEMPT_EN = (MAX_HOLD > 0) && (N > 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]     state;
    logic [0:0]     state_n;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_n;
    logic [HW-1:0]  hold;
    logic [HW-1:0]  hold_n;
    logic [N-1:0]   gnt_n;
    logic [IDW-1:0] gnt_id_n;
    logic           preempt_n;
    logic [IDW:0]   idle_pick;
    logic [IDW:0]   next_pick;
    logic [IDW-1:0] next_owner;
    logic           limit_hit;

    // Wrap-around priority search: the MSB of the result flags whether any candidate was found.
    function automatic logic [IDW:0] find_next(
        input logic [N-1:0]   vec,
        input logic [IDW-1:0] start,
        input logic           excl_en,
        input logic [IDW-1:0] excl
    );
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] pos;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 2 * N; i++) begin
            pos = IDW'((int'(start) + i) % N);
            if (!found && vec[pos] && !(excl_en && (pos == excl))) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [IDW-1:0] next_index(input logic [IDW-1:0] k);
        int t;
        t = int'(k) + 1;
        if (t >= N) begin
            t = 0;
        end
        return IDW'(t);
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    always_comb begin
        next_owner = next_index(gnt_id);
        idle_pick  = find_next(req, ptr, 1'b0, '0);
        next_pick  = find_next(req, next_owner, 1'b1, gnt_id);
        limit_hit  = PREEMPT_EN && (hold == HOLD_LAST);
    end

    // Release hands over on the same edge so a waiting requester never sees a bubble cycle.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        preempt_n = 1'b0;
        case (state)
            IDLE: begin
                if (idle_pick[IDW]) begin
                    gnt_n    = to_onehot(idle_pick[IDW-1:0]);
                    gnt_id_n = idle_pick[IDW-1:0];
                    hold_n   = '0;
                    state_n  = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    ptr_n  = next_owner;
                    hold_n = '0;
                    if (next_pick[IDW]) begin
                        gnt_n    = to_onehot(next_pick[IDW-1:0]);
                        gnt_id_n = next_pick[IDW-1:0];
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (limit_hit && next_pick[IDW]) begin
                    gnt_n     = to_onehot(next_pick[IDW-1:0]);
                    gnt_id_n  = next_pick[IDW-1:0];
                    ptr_n     = next_owner;
                    hold_n    = '0;
                    preempt_n = 1'b1;
                end else if (hold != HOLD_LAST) begin
                    hold_n = hold + HW'(1);
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold      <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold      <= hold_n;
            gnt       <= gnt_n;
            gnt_id    <= gnt_id_n;
            gnt_valid <= |gnt_n;
            preempt   <= preempt_n;
        end
    end

`ifdef RR_LOCK_ARBITER_ASSERT_EN
    logic [N-1:0] req_prev;
    logic [N-1:0] gnt_prev;
    int           run_len;

    // run_len counts consecutive observed cycles of the current grant, capped just above MAX_HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev <= '0;
            gnt_prev <= '0;
            run_len  <= 0;
        end else begin
            assert ($onehot0(gnt));
            assert (gnt_valid == (|gnt));
            assert (!gnt_valid || gnt[gnt_id]);
            assert ((gnt & ~req_prev) == '0);
            assert (!preempt || (run_len == MAX_HOLD));
            req_prev <= req;
            gnt_prev <= gnt;
            if ((gnt != '0) && (gnt == gnt_prev)) begin
                run_len <= (run_len > MAX_HOLD) ? run_len : run_len + 1;
            end else begin
                run_len <= (gnt != '0) ? 1 : 0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: table of per-cycle vectors plus hand-written corner sequences.
module tb_rr_lock_arbiter;

    typedef struct {
        logic       rst_v;
        logic [3:0] req_v;
        logic [3:0] gnt_e;
        logic [1:0] id_e;
        logic       valid_e;
        logic       pre_e;
        logic       chk_id;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    logic [3:0] gnt_u;
    logic [1:0] gnt_id_u;
    logic       gnt_valid_u;
    logic       preempt_u;

    logic [0:0] gnt_s;
    logic [0:0] gnt_id_s;
    logic       gnt_valid_s;
    logic       preempt_s;

    int   tests;
    int   failures;
    vec_t tbl[$];

    rr_lock_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .preempt(preempt)
    );

    rr_lock_arbiter #(.N(4), .MAX_HOLD(0)) dut_unl (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_u), .gnt_id(gnt_id_u), .gnt_valid(gnt_valid_u), .preempt(preempt_u)
    );

    rr_lock_arbiter #(.N(1), .MAX_HOLD(4)) dut_single (
        .clk(clk), .rst(rst), .req(req[0:0]),
        .gnt(gnt_s), .gnt_id(gnt_id_s), .gnt_valid(gnt_valid_s), .preempt(preempt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle from a negedge, then checks the single-requester instance, which must mirror req[0].
    task automatic applyStimulus(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        @(negedge clk);
        checkOutput("single gnt", 32'(gnt_s), 32'(r ? 1'b0 : q[0]));
        checkOutput("single gnt_valid", 32'(gnt_valid_s), 32'(r ? 1'b0 : q[0]));
        checkOutput("single gnt_id", 32'(gnt_id_s), 32'(0));
        checkOutput("single preempt", 32'(preempt_s), 32'(0));
    endtask

    task automatic addVec(input logic r, input logic [3:0] q, input logic [3:0] g,
                          input logic [1:0] gi, input logic v, input logic p, input logic c);
        tbl.push_back('{r, q, g, gi, v, p, c});
    endtask

    initial begin
        int pulses;
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b1111;

        // Reset with everyone requesting, then the first grant goes to requester 0.
        addVec(1, 4'b1111, 4'b0000, 2'd0, 0, 0, 1);
        addVec(1, 4'b1111, 4'b0000, 2'd0, 0, 0, 1);
        addVec(0, 4'b1111, 4'b0001, 2'd0, 1, 0, 1);
        // Full contention: each owner keeps the grant for four cycles, handoff pulses preempt.
        for (int k = 0; k < 3; k++) addVec(0, 4'b1111, 4'b0001, 2'd0, 1, 0, 1);
        addVec(0, 4'b1111, 4'b0010, 2'd1, 1, 1, 1);
        for (int k = 0; k < 3; k++) addVec(0, 4'b1111, 4'b0010, 2'd1, 1, 0, 1);
        addVec(0, 4'b1111, 4'b0100, 2'd2, 1, 1, 1);
        for (int k = 0; k < 3; k++) addVec(0, 4'b1111, 4'b0100, 2'd2, 1, 0, 1);
        addVec(0, 4'b1111, 4'b1000, 2'd3, 1, 1, 1);
        for (int k = 0; k < 3; k++) addVec(0, 4'b1111, 4'b1000, 2'd3, 1, 0, 1);
        addVec(0, 4'b1111, 4'b0001, 2'd0, 1, 1, 1);
        // Release hands over without a bubble, including the wrap from 3 back to 0.
        addVec(0, 4'b0101, 4'b0001, 2'd0, 1, 0, 1);
        addVec(0, 4'b0100, 4'b0100, 2'd2, 1, 0, 1);
        addVec(0, 4'b1000, 4'b1000, 2'd3, 1, 0, 1);
        addVec(0, 4'b1001, 4'b1000, 2'd3, 1, 0, 1);
        addVec(0, 4'b0001, 4'b0001, 2'd0, 1, 0, 1);
        addVec(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
        addVec(0, 4'b0100, 4'b0100, 2'd2, 1, 0, 1);
        addVec(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst_v, tbl[i].req_v);
            checkOutput($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt_e));
            checkOutput($sformatf("row%0d gnt_valid", i), 32'(gnt_valid), 32'(tbl[i].valid_e));
            checkOutput($sformatf("row%0d preempt", i), 32'(preempt), 32'(tbl[i].pre_e));
            if (tbl[i].chk_id) begin
                checkOutput($sformatf("row%0d gnt_id", i), 32'(gnt_id), 32'(tbl[i].id_e));
            end
        end

        // Lone requester (pointer now at 3, so search wraps to 1) keeps the grant with no preempt.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 4'b0010);
            checkOutput($sformatf("lone c%0d gnt", k), 32'(gnt), 32'(4'b0010));
            checkOutput($sformatf("lone c%0d gnt_id", k), 32'(gnt_id), 32'(1));
            checkOutput($sformatf("lone c%0d preempt", k), 32'(preempt), 32'(0));
        end
        applyStimulus(0, 4'b0000);
        checkOutput("lone drop gnt_valid", 32'(gnt_valid), 32'(0));

        // Unlimited hold keeps owner 0 despite a contender; the limited instance preempts every 4 cycles.
        applyStimulus(1, 4'b0000);
        checkOutput("unl reset gnt", 32'(gnt_u), 32'(0));
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 4'b0011);
            checkOutput($sformatf("unl c%0d gnt", k), 32'(gnt_u), 32'(4'b0001));
            checkOutput($sformatf("unl c%0d preempt", k), 32'(preempt_u), 32'(0));
            if (preempt) pulses++;
        end
        checkOutput("limited preempt pulses", 32'(pulses), 32'(4));

        // Reset in the middle of a grant (owner 2, hold 2) clears everything and the pointer.
        applyStimulus(1, 4'b0000);
        applyStimulus(0, 4'b0100);
        checkOutput("mid gnt a", 32'(gnt), 32'(4'b0100));
        applyStimulus(0, 4'b1111);
        checkOutput("mid gnt b", 32'(gnt), 32'(4'b0100));
        applyStimulus(0, 4'b1111);
        checkOutput("mid gnt c", 32'(gnt), 32'(4'b0100));
        applyStimulus(1, 4'b1111);
        checkOutput("mid rst gnt", 32'(gnt), 32'(0));
        checkOutput("mid rst gnt_id", 32'(gnt_id), 32'(0));
        checkOutput("mid rst gnt_valid", 32'(gnt_valid), 32'(0));
        checkOutput("mid rst preempt", 32'(preempt), 32'(0));
        applyStimulus(0, 4'b1111);
        checkOutput("post rst gnt", 32'(gnt), 32'(4'b0001));
        checkOutput("post rst gnt_id", 32'(gnt_id), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
